prog_div: RTL and testbench

PROG_DIV -- requirements
Module: prog_div

---
 rtl/prog_div.sv | 133 +++++++++++++
 tb/tb_prog_div.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/prog_div.sv
// Programmable clock divider: CH duty-cycle outputs share one period counter.
// New ratio/duty configurations are staged in shadow registers and applied at a period wrap.
// Optional PROG_DIV_TICK_EN adds tick_sig, a one-cycle pulse after each enabled wrap.
module prog_div #(
  parameter int unsigned W        = 8,
  parameter int unsigned CH       = 2,
  parameter int unsigned DEF_NUM  = 4,
  parameter int unsigned DEF_DUTY = 2
) (
  input  logic            clk_sig,
  input  logic            reset_sig,
  input  logic            en_sig,
  input  logic            cfg_valid,
  output logic            cfg_ready,
  input  logic [W-1:0]    cfg_num,
  input  logic [CH*W-1:0] cfg_duty,
  output logic            cfg_err,
  output logic [CH-1:0]   div_sig
`ifdef PROG_DIV_TICK_EN
  ,
  output logic            tick_sig
`endif
);

  localparam logic [W-1:0]         NUM_RST  = W'(DEF_NUM);
  localparam logic [CH-1:0][W-1:0] DUTY_RST = {CH{W'(DEF_DUTY)}};

  typedef enum logic {ST_IDLE, ST_PEND} state_e;

  state_e                 state_q, state_d;
  logic [W-1:0]           cnt_q, cnt_d;
  logic [W-1:0]           num_act_q, num_act_d;
  logic [CH-1:0][W-1:0]   duty_act_q, duty_act_d;
  logic [W-1:0]           num_sh_q, num_sh_d;
  logic [CH-1:0][W-1:0]   duty_sh_q, duty_sh_d;
  logic [CH-1:0]          div_q, div_d;
  logic                   err_q, err_d;
  logic                   wrap;
  logic                   accept;
  logic                   reject;

  assign wrap = (cnt_q == num_act_q - W'(1));

  // State register
  always_ff @(posedge clk_sig or negedge reset_sig) begin
    if (!reset_sig) state_q <= ST_IDLE;
    else            state_q <= state_d;
  end

  // Next-state: a staged request stays pending until an enabled wrap applies it
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept)        state_d = ST_PEND;
      ST_PEND: if (en_sig && wrap) state_d = ST_IDLE;
    endcase
  end

  // Handshake outputs
  always_comb begin
    cfg_ready = (state_q == ST_IDLE);
    accept    = cfg_valid && cfg_ready && (cfg_num >= W'(2));
    reject    = cfg_valid && cfg_ready && (cfg_num <  W'(2));
  end

  // Datapath: outputs compare the pre-update count, so new settings show one edge after the wrap
  always_comb begin
    cnt_d      = cnt_q;
    num_act_d  = num_act_q;
    duty_act_d = duty_act_q;
    num_sh_d   = num_sh_q;
    duty_sh_d  = duty_sh_q;
    div_d      = div_q;
    err_d      = reject;
    if (en_sig) begin
      for (int unsigned i = 0; i < CH; i++) begin
        div_d[i] = (cnt_q < duty_act_q[i]);
      end
      if (wrap) begin
        cnt_d = '0;
        if (state_q == ST_PEND) begin
          num_act_d  = num_sh_q;
          duty_act_d = duty_sh_q;
        end
      end else begin
        cnt_d = cnt_q + W'(1);
      end
    end
    if (accept) begin
      num_sh_d  = cfg_num;
      duty_sh_d = cfg_duty;
    end
  end

  always_ff @(posedge clk_sig or negedge reset_sig) begin
    if (!reset_sig) begin
      cnt_q      <= '0;
      num_act_q  <= NUM_RST;
      duty_act_q <= DUTY_RST;
      num_sh_q   <= NUM_RST;
      duty_sh_q  <= DUTY_RST;
      div_q      <= '0;
      err_q      <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      num_act_q  <= num_act_d;
      duty_act_q <= duty_act_d;
      num_sh_q   <= num_sh_d;
      duty_sh_q  <= duty_sh_d;
      div_q      <= div_d;
      err_q      <= err_d;
    end
  end

  assign div_sig = div_q;
  assign cfg_err = err_q;

`ifdef PROG_DIV_TICK_EN
  logic tick_q, tick_d;

  always_comb begin
    tick_d = en_sig && wrap;
  end

  always_ff @(posedge clk_sig or negedge reset_sig) begin
    if (!reset_sig) tick_q <= 1'b0;
    else            tick_q <= tick_d;
  end

  assign tick_sig = tick_q;
`endif

endmodule

// File: tb/tb_prog_div.sv
// Scoreboard bench for prog_div: a period/phase reference model queues the expected
// registered outputs per edge; a monitor compares them one time unit after each rising edge.
module tb_prog_div;

  localparam int W  = 8;
  localparam int CH = 2;

  logic            clk_sig = 1'b0;
  logic            reset_sig;
  logic            en_sig;
  logic            cfg_valid;
  logic            cfg_ready;
  logic [W-1:0]    cfg_num;
  logic [CH*W-1:0] cfg_duty;
  logic            cfg_err;
  logic [CH-1:0]   div_sig;
`ifdef PROG_DIV_TICK_EN
  logic            tick_sig;
`endif

  prog_div #(.W(W), .CH(CH), .DEF_NUM(4), .DEF_DUTY(2)) dut (
    .clk_sig   (clk_sig),
    .reset_sig (reset_sig),
    .en_sig    (en_sig),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_num   (cfg_num),
    .cfg_duty  (cfg_duty),
    .cfg_err   (cfg_err),
    .div_sig   (div_sig)
`ifdef PROG_DIV_TICK_EN
    ,
    .tick_sig  (tick_sig)
`endif
  );

  always #5 clk_sig = ~clk_sig;

  typedef struct {
    logic [CH-1:0] div;
    logic          rdy;
    logic          err;
    logic          tick;
    bit            chk_rdy;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: period length, per-channel high counts, position in the period,
  // and at most one staged request.
  int            per;
  int            duty[CH];
  int            phase;
  bit            pend;
  int            sh_per;
  int            sh_duty[CH];
  logic [CH-1:0] div_m;

  function automatic void model_reset();
    per = 4; phase = 0; pend = 0; sh_per = 4; div_m = '0;
    for (int i = 0; i < CH; i++) begin
      duty[i] = 2; sh_duty[i] = 2;
    end
  endfunction

  function automatic void model_step(bit rst_n, bit en, bit v, int num, int d0, int d1);
    exp_t e;
    bit   rdy_now;
    bit   tk;
    bit   er;
    tk = 0; er = 0;
    if (!rst_n) begin
      model_reset();
      e = '{div: '0, rdy: 1'b1, err: 1'b0, tick: 1'b0, chk_rdy: 1'b0};
      exp_q.push_back(e);
      return;
    end
    rdy_now = !pend;
    if (en) begin
      for (int i = 0; i < CH; i++) div_m[i] = (phase < duty[i]);
      if (phase == per - 1) begin
        tk = 1;
        phase = 0;
        if (pend) begin
          per = sh_per;
          duty = sh_duty;
          pend = 0;
        end
      end else begin
        phase = phase + 1;
      end
    end
    if (v && rdy_now) begin
      if (num >= 2) begin
        sh_per = num; sh_duty[0] = d0; sh_duty[1] = d1; pend = 1;
      end else begin
        er = 1;
      end
    end
    e = '{div: div_m, rdy: !pend, err: er, tick: tk, chk_rdy: 1'b1};
    exp_q.push_back(e);
  endfunction

  task automatic cycle(input bit rst_n, input bit en, input bit v,
                       input int num, input int d0, input int d1);
    @(negedge clk_sig);
    reset_sig = rst_n;
    en_sig    = en;
    cfg_valid = v;
    cfg_num   = W'(num);
    cfg_duty  = {W'(d1), W'(d0)};
    model_step(rst_n, en, v, num, d0, d1);
  endtask

  task automatic idle(input int n, input bit en);
    for (int k = 0; k < n; k++) cycle(1, en, 0, 0, 0, 0);
  endtask

  // Monitor
  initial begin
    exp_t e;
    logic act_tick;
    forever begin
      @(posedge clk_sig);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
`ifdef PROG_DIV_TICK_EN
        act_tick = tick_sig;
`else
        act_tick = e.tick;
`endif
        checks++;
        if (div_sig !== e.div || cfg_err !== e.err || act_tick !== e.tick ||
            (e.chk_rdy && cfg_ready !== e.rdy)) begin
          errors++;
          $display("FAIL outputs t=%0t got div=%b rdy=%b err=%b tick=%b want div=%b rdy=%b err=%b tick=%b",
                   $time, div_sig, cfg_ready, cfg_err, act_tick, e.div, e.rdy, e.err, e.tick);
        end
      end
    end
  end

  // Stimulus
  initial begin
    bit found;
    reset_sig = 1'b0; en_sig = 1'b0; cfg_valid = 1'b0; cfg_num = '0; cfg_duty = '0;
    model_reset();

    for (int k = 0; k < 3; k++) cycle(0, 0, 0, 0, 0, 0);
    idle(2, 0);
    // Defaults 4/2
    idle(14, 1);
    // Mid-period request num=5, duty ch0=0 ch1=3
    idle(1, 1);
    cycle(1, 1, 1, 5, 0, 3);
    idle(16, 1);
    // Rejected request
    cycle(1, 1, 1, 1, 3, 3);
    idle(6, 1);
    // num=3, duty ch0=7 ch1=1, then frozen while disabled
    cycle(1, 1, 1, 3, 7, 1);
    idle(20, 0);
    idle(12, 1);
    // Request issued exactly on a wrap edge
    found = 0;
    for (int k = 0; k < 50 && !found; k++) begin
      if (phase == per - 1 && !pend) found = 1;
      else idle(1, 1);
    end
    if (!found) begin
      checks++; errors++;
      $display("FAIL wrap_wait timed out got found=0 want found=1");
    end
    cycle(1, 1, 1, 6, 2, 4);
    idle(20, 1);
    // Async reset while a request is pending and outputs are high
    cycle(1, 1, 1, 7, 5, 5);
    found = 0;
    for (int k = 0; k < 20 && !found; k++) begin
      if (div_m == '1 && pend) found = 1;
      else idle(1, 1);
    end
    if (!found) begin
      checks++; errors++;
      $display("FAIL async_setup timed out got found=0 want found=1");
    end
    @(posedge clk_sig);
    #3;
    reset_sig = 1'b0;
    #1;
    checks++;
    if (div_sig !== '0 || cfg_err !== 1'b0
`ifdef PROG_DIV_TICK_EN
        || tick_sig !== 1'b0
`endif
       ) begin
      errors++;
      $display("FAIL async_reset got div=%b err=%b want div=00 err=0", div_sig, cfg_err);
    end
    cycle(0, 1, 0, 0, 0, 0);
    cycle(0, 1, 0, 0, 0, 0);
    idle(20, 1);
    // Randomised traffic
    for (int k = 0; k < 300; k++) begin
      cycle(1, $urandom_range(0, 9) != 0, $urandom_range(0, 3) == 0,
            int'($urandom_range(0, 12)), int'($urandom_range(0, 14)),
            int'($urandom_range(0, 14)));
    end
    idle(2, 1);
    repeat (3) @(posedge clk_sig);
    #2;
    if (exp_q.size() != 0) begin
      checks++; errors++;
      $display("FAIL drain got %0d pending want 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
